// File: rtl/pc_alu_unit.sv
// Program counter, carry-in adder ALU and haltable cycle counter for the 8-bit CPU.
// The PC and cycle counter are registered; the ALU is purely combinational.
module pc_alu_unit #(
  parameter int WIDTH     = 8,
  parameter int CYC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 halt,
  input  logic                 pc_ce,
  input  logic                 pc_j,
  input  logic [WIDTH-1:0]     pc_din,
  output logic [WIDTH-1:0]     pc_out,
  input  logic                 alu_cin,
  input  logic [WIDTH-1:0]     alu_a,
  input  logic [WIDTH-1:0]     alu_b,
  output logic [WIDTH-1:0]     alu_sum,
  output logic                 alu_cout,
  output logic                 alu_zero,
  output logic [CYC_WIDTH-1:0] cycle_cnt
);

  logic [WIDTH:0] alu_full;

  // Priority: reset > halt > jump > count > hold. Halt freezes both PC and timebase.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out    <= '0;
      cycle_cnt <= '0;
    end else if (!halt) begin
      cycle_cnt <= cycle_cnt + CYC_WIDTH'(1);
      if (pc_j) begin
        pc_out <= pc_din;
      end else if (pc_ce) begin
        pc_out <= pc_out + WIDTH'(1);
      end
    end
  end

  // Sum is formed one bit wider so the carry falls out as the top bit.
  always_comb begin
    alu_full = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, alu_cin};
    alu_sum  = alu_full[WIDTH-1:0];
    alu_cout = alu_full[WIDTH];
    alu_zero = ~|alu_full[WIDTH-1:0];
  end

endmodule

// File: tb/tb_pc_alu_unit.sv
// Bench for pc_alu_unit: directed spot checks plus randomized traffic compared
// every cycle against an arithmetic model of PC, cycle counter and ALU.
module tb_pc_alu_unit;

  localparam int WIDTH     = 8;
  localparam int CYC_WIDTH = 16;
  localparam int W         = WIDTH + CYC_WIDTH;

  logic                 clk;
  logic                 reset;
  logic                 halt;
  logic                 pc_ce;
  logic                 pc_j;
  logic [WIDTH-1:0]     pc_din;
  logic [WIDTH-1:0]     pc_out;
  logic                 alu_cin;
  logic [WIDTH-1:0]     alu_a;
  logic [WIDTH-1:0]     alu_b;
  logic [WIDTH-1:0]     alu_sum;
  logic                 alu_cout;
  logic                 alu_zero;
  logic [CYC_WIDTH-1:0] cycle_cnt;

  int checks   = 0;
  int failures = 0;

  pc_alu_unit #(.WIDTH(WIDTH), .CYC_WIDTH(CYC_WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .halt      (halt),
    .pc_ce     (pc_ce),
    .pc_j      (pc_j),
    .pc_din    (pc_din),
    .pc_out    (pc_out),
    .alu_cin   (alu_cin),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sum   (alu_sum),
    .alu_cout  (alu_cout),
    .alu_zero  (alu_zero),
    .cycle_cnt (cycle_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // PC and counter kept as plain integers; the rules are applied from the
  // inputs seen at each rising edge.
  int  pc_m    = 0;
  int  cnt_m   = 0;
  bit  m_valid = 1'b0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      pc_m    = 0;
      cnt_m   = 0;
      m_valid = 1'b1;
    end else if (!halt) begin
      cnt_m = (cnt_m + 1) % 65536;
      if (pc_j)       pc_m = int'(pc_din);
      else if (pc_ce) pc_m = (pc_m + 1) % 256;
    end
    if (m_valid) exp_q.push_back(W'((cnt_m << WIDTH) | pc_m));
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    int s;
    if (m_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_queue actual=empty required=entry");
      end else begin
        e = exp_q.pop_front();
        if (pc_out !== e[WIDTH-1:0]) begin
          failures++;
          $display("FAIL sb_pc actual=%h required=%h t=%0t", pc_out, e[WIDTH-1:0], $time);
        end
        checks++;
        if (cycle_cnt !== e[W-1:WIDTH]) begin
          failures++;
          $display("FAIL sb_cnt actual=%0d required=%0d t=%0t", cycle_cnt, e[W-1:WIDTH], $time);
        end
      end
    end
    // ALU checked every cycle, regardless of reset/halt.
    s = int'(alu_a) + int'(alu_b) + int'(alu_cin);
    checks++;
    if ({alu_cout, alu_sum} !== 9'(s) || alu_zero !== ((s % 256) == 0)) begin
      failures++;
      $display("FAIL sb_alu a=%h b=%h cin=%0b actual=%b_%h_z%0b required=%h",
               alu_a, alu_b, alu_cin, alu_cout, alu_sum, alu_zero, 9'(s));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic r, input logic h, input logic j, input logic ce,
                        input logic [WIDTH-1:0] din);
    reset  = r;
    halt   = h;
    pc_j   = j;
    pc_ce  = ce;
    pc_din = din;
  endtask

  task automatic set_alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    alu_a   = a;
    alu_b   = b;
    alu_cin = c;
  endtask

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_pc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    set_alu(8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check("rst_pc", int'(pc_out), 0);
    check("rst_cnt", int'(cycle_cnt), 0);

    set_pc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(3);
    check("hold_pc", int'(pc_out), 0);
    check("hold_cnt", int'(cycle_cnt), 3);

    set_pc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick(5);
    check("inc5_pc", int'(pc_out), 5);
    check("inc5_cnt", int'(cycle_cnt), 8);

    set_pc(1'b0, 1'b0, 1'b1, 1'b0, 8'hFE);
    tick(1);
    check("load_fe", int'(pc_out), 'hFE);
    set_pc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick(1);
    check("inc_ff", int'(pc_out), 'hFF);
    tick(1);
    check("wrap_00", int'(pc_out), 'h00);
    tick(1);
    check("inc_01", int'(pc_out), 'h01);

    set_pc(1'b0, 1'b0, 1'b1, 1'b1, 8'h42);
    tick(1);
    check("jump_wins", int'(pc_out), 'h42);
    check("cnt_13", int'(cycle_cnt), 13);
    set_pc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    tick(3);
    check("halt_pc", int'(pc_out), 'h42);
    check("halt_cnt", int'(cycle_cnt), 13);

    set_alu(8'h05, 8'h03, 1'b0);
    #1;
    check("alu_5_3", int'({alu_zero, alu_cout, alu_sum}), 'h008);
    set_alu(8'hFF, 8'h01, 1'b0);
    #1;
    check("alu_ff_1", int'({alu_zero, alu_cout, alu_sum}), 'h300);
    set_alu(8'hFF, 8'hFF, 1'b1);
    #1;
    check("alu_ff_ff_c", int'({alu_cout, alu_sum}), 'h1FF);

    set_pc(1'b0, 1'b0, 1'b1, 1'b0, 8'h10);
    tick(1);
    check("load_10", int'(pc_out), 'h10);
    set_pc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    tick(1);
    check("midrst_pc", int'(pc_out), 0);
    check("midrst_cnt", int'(cycle_cnt), 0);
    check("alu_in_rst", int'({alu_cout, alu_sum}), 'h1FF);
    set_pc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick(1);
    check("post_rst_pc", int'(pc_out), 1);

    // Randomized traffic; the scoreboard checks every cycle.
    for (int i = 0; i < 1000; i++) begin
      set_alu(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      set_pc(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
             8'($urandom_range(0, 255)));
      tick(1);
    end

    set_pc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
